// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  // Bit-counter width: enough to count 0..width-1, never narrower than 1 bit.
  function automatic int sa_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/half_adder.sv
// Half-adder cell: sum = a ^ b, carry = a & b.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_adder_fa_bit.sv
// Purely combinational full-adder slice made of two half adders and an OR.
module fa_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .i_a     (i_a),
    .i_b     (i_b),
    .o_sum   (w_s0),
    .o_carry (w_c0)
  );

  half_adder u_ha1 (
    .i_a     (w_s0),
    .i_b     (i_cin),
    .o_sum   (o_sum),
    .o_carry (w_c1)
  );

  // The two half-adder carries can never both be high, so OR is exact.
  assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice, registered carry, LSB first.
// Handshake: start is accepted on a rising edge whenever the FSM is not in
// SHIFT (IDLE or DONE); a/b/cin are captured on that same edge. done is a
// one-cycle pulse marking sum/c_out as a fresh result; there is no back-pressure.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = sa_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_psum_next;

  assign w_accept = start && (r_state != SHIFT);
  assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_BIT);

  fa_bit u_fa (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_psum_next = (r_psum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? SHIFT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state register only.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, one bit per SHIFT cycle, result load on last bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_psum  <= w_psum_next;
      r_carry <= w_co;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_sum  <= w_psum_next;
        r_cout <= w_co;
      end
    end
  end

  assign sum       = r_sum;
  assign c_out     = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 builds).
module tb_serial_adder;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       c_out;
  logic [1:0] dbg_state;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       c_out1;
  logic [1:0] dbg_state1;

  int n_checks;
  int n_errors;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .c_out     (c_out),
    .dbg_state (dbg_state)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .c_out     (c_out1),
    .dbg_state (dbg_state1)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sample 1ns later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait for done on the WIDTH=8 DUT; lat = edges after the start edge.
  task automatic wait_done8(output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    while (!done && lat < 30) begin
      if (busy) nbusy++;
      cycle();
      lat++;
    end
  endtask

  // Full add on WIDTH=8 DUT with latency, busy length and result checks.
  task automatic add8(input string tag, input logic [7:0] va, input logic [7:0] vb,
                      input logic vc, input logic [7:0] exp_sum, input logic exp_c);
    int lat, nbusy;
    a = va; b = vb; cin = vc; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_done8(lat, nbusy);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_busy_len"}, nbusy, 8);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, c_out, exp_c);
    check({tag, "_busy_in_done"}, busy, 0);
    cycle();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int lat, nbusy, extra;
    n_checks = 0;
    n_errors = 0;
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    reset_n = 1'b0;
    #2;

    // Reset held with start asserted.
    cycle();
    cycle();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", c_out, 0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_w1_sum", sum1, 0);
    start = 1'b0; start1 = 1'b0;
    reset_n = 1'b1;
    cycle();
    check("idle_busy", busy, 0);

    // Basic add and carry ripple.
    add8("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    add8("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    add8("ripple2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    add8("cin_only", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);
    // Result holds through IDLE.
    cycle();
    check("hold_sum", sum, 8'h80);

    // Start and operand changes during SHIFT are ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    check("midop_sum_held", sum, 8'h80);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    cycle();
    start = 1'b0;
    lat = 0; nbusy = 0;
    while (!done && lat < 30) begin cycle(); lat++; end
    check("ign_lat", lat + 3, 8);
    check("ign_sum", sum, 8'h30);
    check("ign_cout", c_out, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done) extra++;
    end
    check("ign_single_done", extra, 0);

    // Back-to-back: start held through the DONE cycle.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    cycle();
    wait_done8(lat, nbusy);
    check("b2b1_lat", lat, 8);
    check("b2b1_sum", sum, 8'h03);
    a = 8'h10; b = 8'h07;
    cycle();
    start = 1'b0;
    check("b2b_restart_busy", busy, 1);
    check("b2b_sum_held", sum, 8'h03);
    wait_done8(lat, nbusy);
    check("b2b2_lat", lat, 8);
    check("b2b2_sum", sum, 8'h17);
    check("b2b2_cout", c_out, 0);
    cycle();

    // Reset in the middle of an add.
    a = 8'h12; b = 8'h34; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_sum", sum, 8'h00);
    check("mrst_cout", c_out, 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (done) extra++;
    end
    check("mrst_no_done", extra, 0);
    add8("after_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // WIDTH=1 build.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    cycle();
    start1 = 1'b0;
    check("w1_busy", busy1, 1);
    cycle();
    check("w1_done", done1, 1);
    check("w1_sum", sum1, 1);
    check("w1_cout", c_out1, 1);
    cycle();
    check("w1_done_drop", done1, 0);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    cycle();
    start1 = 1'b0;
    cycle();
    check("w1b_done", done1, 1);
    check("w1b_sum", sum1, 1);
    check("w1b_cout", c_out1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle bit-serial adder. Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Each bit position is computed by a single registered-carry full-adder slice, which is built from two half-adder cells and an OR gate.
- Sits upstream of datapath blocks that want a low-area add with a start/done handshake instead of a wide combinational adder.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  request to begin an add; sampled on the rising edge of clk
- a  input  WIDTH  operand A; captured only on the edge where start is accepted
- b  input  WIDTH  operand B; captured only on the edge where start is accepted
- cin  input  1  carry-in; captured only on the edge where start is accepted
- busy  output  1  high while an add is in progress
- done  output  1  one-cycle pulse; high when sum and c_out are valid for a new result
- sum  output  WIDTH  result bits, registered
- c_out  output  1  final carry-out, registered

Behaviour:
- Reset: one clock, one reset. reset_n is synchronous and active-low; it is sampled on the rising edge of clk.
  - While reset_n=0, every register clears on the edge: state=IDLE, busy=0, done=0, sum=0, c_out=0, bit counter=0, carry=0, operand shift registers=0.
  - Reset asserted mid-operation aborts the add. No done pulse is issued and sum/c_out read 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0. If start=1 on an edge: capture a, b, cin into shift regs A, B and carry reg; clear counter; go to SHIFT.
  - SHIFT: busy=1. Each edge, the slice adds A[0], B[0] and carry:
    - the sum bit shifts into the MSB of the partial-sum register (shift right);
    - carry reg <= carry-out;
    - A and B shift right;
    - counter increments.
  - On the edge where counter==WIDTH-1, perform that final bit and then:
    - load sum <= full partial-sum value;
    - load c_out <= final carry;
    - go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle.
    - If start=1 on this edge, the new operands are captured and the FSM goes to SHIFT (back-to-back operation).
    - Otherwise the FSM goes to IDLE.
- Latency: start accepted on edge E. Bit additions occur on edges E+1 .. E+WIDTH. done=1 during the cycle after edge E+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while in SHIFT is ignored. Operand changes while busy have no effect.
- sum and c_out change only when a result completes (or on reset). They hold the last result through IDLE and through the next operation until it completes.
- Width rules:
  - result = a + b + cin, modulo 2^WIDTH in sum; the bit at weight 2^WIDTH goes to c_out.
  - Counter width is max(1, $clog2(WIDTH)).
  - WIDTH=1: exactly one SHIFT cycle.
- busy and done are registered outputs decoded from state (no combinational input-to-output path).

Decomposition:
- Shared package serial_adder_pkg holds:
  - state typedef sa_state_t {IDLE, SHIFT, DONE} with 2-bit encoding;
  - a localparam helper for counter width.
- One sub-module: fa_bit, a purely combinational full adder (a, b, cin -> sum, c_out).
  - Built from two instances of the existing half-adder cell plus an OR of their carries.
  - Instantiated once inside serial_adder.
  - Carry storage lives in serial_adder, not in fa_bit.

Test Plan (WIDTH=8 unless stated):
- Reset: hold reset_n=0 for 2 cycles with start=1 -> busy=0, done=0, sum=0x00, c_out=0. The FSM stays IDLE.
- Basic add: a=0x5A, b=0x3C, cin=0, pulse start -> busy high for 8 cycles; done pulses 9 cycles after the start edge; sum=0x96, c_out=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, c_out=1.
- Ignored start and operand changes: start a=0x10, b=0x20. Pulse start and change a/b to 0xAA/0x55 at cycle 3 of SHIFT -> result still sum=0x30. Exactly one done pulse.
- Back-to-back: hold start=1 with a=0x01, b=0x02 through the DONE cycle -> first done gives sum=0x03 and a second operation begins immediately. A second done pulse arrives 9 cycles later.
- Reset mid-op: assert reset_n=0 at SHIFT cycle 4 -> next edge busy=0, done never pulses, sum=0x00. A subsequent start with a=0x80, b=0x80 gives sum=0x00, c_out=1.
- WIDTH=1 build: a=1, b=1, cin=1 -> done two cycles after start, sum=1, c_out=1.
